v8cpu_exec: RTL and testbench

Single-issue execute/writeback stage for the v8cpu datapath, sitting directly upstream of `vcpu_alu`. It accepts one decoded instruction at a time over a valid/ready handshake and reads two operands from an internal 8×8-bit register file. It drives the ALU's `op`/`a`/`b` inputs from registered operand latches, then writes `c` back to the destination register and latches `flag_eq`. It also provides a combinational debug read port into the register file.

---
 rtl/v8cpu_exec.sv | 109 ++++++++++
 tb/tb_v8cpu_exec.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/v8cpu_exec.sv
// v8cpu execute/writeback stage: register file, ALU operand latches, writeback.
// Define V8CPU_EXEC_SETTLE_EN to add a SETTLE cycle before writeback.
module v8cpu_exec #(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_ra,
  input  logic [2:0] in_rb,
  input  logic [7:0] in_imm,
  input  logic       in_use_imm,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_c,
  input  logic       alu_eq,
  output logic       flag_eq,
  output logic       done,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SETTLE
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic       accept;
  logic       wbEn;
  logic [2:0] rdLat;
  logic       isLdi;
  logic [7:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    wbEn      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: begin
`ifdef V8CPU_EXEC_SETTLE_EN
        stateNext = SETTLE;
`else
        wbEn      = 1'b1;
        stateNext = IDLE;
`endif
      end
      SETTLE: begin
        wbEn      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign dbg_data = regs[dbg_sel];

  // LDI writes back the latched immediate and leaves flag_eq alone
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      rdLat   <= '0;
      isLdi   <= 1'b0;
      flag_eq <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      done <= wbEn;
      if (accept) begin
        alu_op <= in_op;
        alu_a  <= regs[in_ra];
        alu_b  <= in_use_imm ? in_imm
                             : regs[in_rb];
        rdLat  <= in_rd;
        isLdi  <= (in_op == 3'b111);
      end
      if (wbEn) begin
        if (isLdi) begin
          regs[rdLat] <= alu_b;
        end else begin
          regs[rdLat] <= alu_c;
          flag_eq     <= alu_eq;
        end
      end
    end
  end

endmodule

// File: tb/tb_v8cpu_exec.sv
// Directed bench for v8cpu_exec with an add/eq ALU stub.
// Vector table plus streaming and reset-abort sequences.
module tb_v8cpu_exec;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [2:0] inOp, inRd, inRa, inRb;
  logic [7:0] inImm;
  logic       inUseImm;
  logic [2:0] aluOp;
  logic [7:0] aluA, aluB, aluC;
  logic       aluEq;
  logic       flagEq;
  logic       done;
  logic [2:0] dbgSel;
  logic [7:0] dbgData;

  int nChecks = 0;
  int nFails  = 0;

`ifdef V8CPU_EXEC_SETTLE_EN
  localparam int LAT  = 3;
  localparam int BUSY = 2;
`else
  localparam int LAT  = 2;
  localparam int BUSY = 1;
`endif

  always #5 clk = ~clk;

  assign aluC  = (aluOp == 3'd0) ? aluA + aluB : aluA ^ aluB;
  assign aluEq = (aluA == aluB);

  v8cpu_exec dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_op      (inOp),
    .in_rd      (inRd),
    .in_ra      (inRa),
    .in_rb      (inRb),
    .in_imm     (inImm),
    .in_use_imm (inUseImm),
    .alu_op     (aluOp),
    .alu_a      (aluA),
    .alu_b      (aluB),
    .alu_c      (aluC),
    .alu_eq     (aluEq),
    .flag_eq    (flagEq),
    .done       (done),
    .dbg_sel    (dbgSel),
    .dbg_data   (dbgData)
  );

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
    logic       useImm;
    logic [7:0] expA;
    logic [7:0] expB;
    logic [7:0] expRd;
    logic       expFlag;
  } vec_t;

  vec_t vecs [8];
  vec_t strm [4];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkReg(input logic [2:0] r, input int exp);
    dbgSel = r;
    #1;
    chk($sformatf("dbg r%0d", r), int'(dbgData), exp);
  endtask

  task automatic drive(input vec_t v);
    inValid  = 1'b1;
    inOp     = v.op;
    inRd     = v.rd;
    inRa     = v.ra;
    inRb     = v.rb;
    inImm    = v.imm;
    inUseImm = v.useImm;
  endtask

  initial begin
    int lat;
    int acc;
    int dCnt;
    int busy;
    int cyc;
    logic willAccept;

    // op, rd, ra, rb, imm, useImm, expA, expB, expRd, expFlag
    vecs[0] = '{3'd7, 3'd1, 3'd0, 3'd0, 8'd23, 1'b1, 8'd0,   8'd23,  8'd23,  1'b0};
    vecs[1] = '{3'd7, 3'd2, 3'd0, 3'd0, 8'd44, 1'b1, 8'd0,   8'd44,  8'd44,  1'b0};
    vecs[2] = '{3'd0, 3'd3, 3'd1, 3'd2, 8'd0,  1'b0, 8'd23,  8'd44,  8'd67,  1'b0};
    vecs[3] = '{3'd0, 3'd3, 3'd1, 3'd2, 8'd23, 1'b1, 8'd23,  8'd23,  8'd46,  1'b1};
    vecs[4] = '{3'd7, 3'd5, 3'd0, 3'd0, 8'd23, 1'b1, 8'd0,   8'd23,  8'd23,  1'b1};
    vecs[5] = '{3'd0, 3'd6, 3'd3, 3'd5, 8'd0,  1'b0, 8'd46,  8'd23,  8'd69,  1'b0};
    vecs[6] = '{3'd0, 3'd0, 3'd6, 3'd6, 8'd0,  1'b0, 8'd69,  8'd69,  8'd138, 1'b1};
    vecs[7] = '{3'd0, 3'd7, 3'd0, 3'd0, 8'd0,  1'b0, 8'd138, 8'd138, 8'd20,  1'b1};

    strm[0] = '{3'd7, 3'd1, 3'd0, 3'd0, 8'd5,  1'b1, 8'd0, 8'd0, 8'd0, 1'b0};
    strm[1] = '{3'd0, 3'd2, 3'd1, 3'd1, 8'd0,  1'b0, 8'd0, 8'd0, 8'd0, 1'b0};
    strm[2] = '{3'd0, 3'd3, 3'd2, 3'd1, 8'd0,  1'b0, 8'd0, 8'd0, 8'd0, 1'b0};
    strm[3] = '{3'd0, 3'd1, 3'd3, 3'd0, 8'd15, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0};

    reset    = 1'b1;
    inValid  = 1'b0;
    inOp     = '0;
    inRd     = '0;
    inRa     = '0;
    inRb     = '0;
    inImm    = '0;
    inUseImm = 1'b0;
    dbgSel   = '0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst in_ready", int'(inReady), 1);
    chk("rst done", int'(done), 0);
    chk("rst flag_eq", int'(flagEq), 0);
    chk("rst alu_op", int'(aluOp), 0);
    chk("rst alu_a", int'(aluA), 0);
    chk("rst alu_b", int'(aluB), 0);
    for (int r = 0; r < 8; r++)
      chkReg(3'(r), 0);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      chk($sformatf("v%0d alu_op", i), int'(aluOp), int'(vecs[i].op));
      chk($sformatf("v%0d alu_a", i), int'(aluA), int'(vecs[i].expA));
      chk($sformatf("v%0d alu_b", i), int'(aluB), int'(vecs[i].expB));
      chk($sformatf("v%0d in_ready", i), int'(inReady), 0);
      chk($sformatf("v%0d done low", i), int'(done), 0);
      lat = 1;
      while (lat < 10) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (done) break;
      end
      chk($sformatf("v%0d latency", i), lat, LAT);
      chkReg(vecs[i].rd, int'(vecs[i].expRd));
      chk($sformatf("v%0d flag_eq", i), int'(flagEq), int'(vecs[i].expFlag));
      chk($sformatf("v%0d ready", i), int'(inReady), 1);
    end

    acc  = 0;
    dCnt = 0;
    busy = 0;
    cyc  = 0;
    while ((acc < 4 || dCnt < 4) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk($sformatf("strm c%0d in_ready", cyc), int'(inReady), int'(busy == 0));
      if (done) dCnt++;
      if (acc < 4) drive(strm[acc]);
      else inValid = 1'b0;
      willAccept = inReady && inValid;
      @(posedge clk);
      if (willAccept) begin
        acc++;
        busy = BUSY;
      end else if (busy > 0) begin
        busy--;
      end
    end
    chk("strm accepts", acc, 4);
    chk("strm dones", dCnt, 4);
    chkReg(3'd2, 10);
    chkReg(3'd3, 15);
    chkReg(3'd1, 30);
    chk("strm flag_eq", int'(flagEq), 1);

    drive('{3'd0, 3'd4, 3'd1, 3'd2, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    chk("abort alu_a", int'(aluA), 30);
    chk("abort alu_b", int'(aluB), 10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", int'(inReady), 1);
    chk("abort done", int'(done), 0);
    chk("abort flag_eq", int'(flagEq), 0);
    chk("abort alu_op", int'(aluOp), 0);
    chk("abort alu_a rst", int'(aluA), 0);
    chk("abort alu_b rst", int'(aluB), 0);
    chkReg(3'd4, 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort no done", int'(done), 0);
    end
    chkReg(3'd4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
